// File: rtl/axil_accel_regbank.sv
// -----------------------------------------------------------------------------
// axil_accel_regbank
//
// AXI4-Lite register front-end for the dot-product accelerator core.
// Holds N_WORDS data words, N_WORDS weight words and a bias word, issues a
// one-cycle start pulse, latches the core result, keeps sticky DONE/ERR status
// (write-1-to-clear) and drives a maskable, registered interrupt.
//
// Word map (k = byte address >> 2, N = N_WORDS):
//   0..N-1   DATA[k]        N..2N-1  WEI[k-N]       2N    BIAS
//   2N+1     CTRL (bit0 START, reads 0)
//   2N+2     STATUS (bit0 DONE W1C, bit1 BUSY live, bit2 ERR W1C)
//   2N+3     RESULT (read-only)         2N+4  IRQ_EN (bit0 done, bit1 err)
//   2N+5     CYCLES (only with ACCEL_REGBANK_PERF_EN, otherwise unmapped)
//
// Optional feature macro: ACCEL_REGBANK_PERF_EN enables the CYCLES counter.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*             AXI4-Lite write address/data/response
//   s_axi_ar*/r*                AXI4-Lite read address/data
//   core_start                  one-cycle start pulse to the core
//   core_data, core_wei         flat operand buses, word i at [32i +: 32]
//   core_bias                   bias word
//   core_busy, core_done        core status (done is a one-cycle pulse)
//   core_result                 result, valid while core_done is high
//   irq                         level interrupt
// Only DATA_WIDTH = 32 is supported.
// -----------------------------------------------------------------------------
module axil_accel_regbank #(
    parameter int N_WORDS    = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          core_start,
    output logic [DATA_WIDTH*N_WORDS-1:0] core_data,
    output logic [DATA_WIDTH*N_WORDS-1:0] core_wei,
    output logic [DATA_WIDTH-1:0]         core_bias,
    input  logic                          core_busy,
    input  logic                          core_done,
    input  logic [DATA_WIDTH-1:0]         core_result,
    output logic                          irq
);

    localparam int KW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;

    localparam logic [KW-1:0] K_WEI    = KW'(N_WORDS);
    localparam logic [KW-1:0] K_BIAS   = KW'(2 * N_WORDS);
    localparam logic [KW-1:0] K_CTRL   = KW'(2 * N_WORDS + 1);
    localparam logic [KW-1:0] K_STATUS = KW'(2 * N_WORDS + 2);
    localparam logic [KW-1:0] K_RESULT = KW'(2 * N_WORDS + 3);
    localparam logic [KW-1:0] K_IRQEN  = KW'(2 * N_WORDS + 4);
    localparam logic [KW-1:0] K_CYCLES = KW'(2 * N_WORDS + 5);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        R_DATA, R_WEI, R_BIAS, R_CTRL, R_STATUS,
        R_RESULT, R_IRQEN, R_CYCLES, R_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode(input logic [KW-1:0] k);
        if (k < K_WEI)          return R_DATA;
        else if (k < K_BIAS)    return R_WEI;
        else if (k == K_BIAS)   return R_BIAS;
        else if (k == K_CTRL)   return R_CTRL;
        else if (k == K_STATUS) return R_STATUS;
        else if (k == K_RESULT) return R_RESULT;
        else if (k == K_IRQEN)  return R_IRQEN;
`ifdef ACCEL_REGBANK_PERF_EN
        else if (k == K_CYCLES) return R_CYCLES;
`endif
        else                    return R_NONE;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0] cur,
                                                         input logic [DATA_WIDTH-1:0] nxt,
                                                         input logic [SW-1:0]         strb);
        logic [DATA_WIDTH-1:0] res;
        res = cur;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
        end
        return res;
    endfunction

    // Register storage
    logic [N_WORDS-1:0][DATA_WIDTH-1:0] data_q;
    logic [N_WORDS-1:0][DATA_WIDTH-1:0] wei_q;
    logic [DATA_WIDTH-1:0]              bias_q;
    logic [DATA_WIDTH-1:0]              result_q;
    logic [1:0]                         irq_en;
    logic                               done_q;
    logic                               err_q;

    // Channel state
    logic                  ready_en;
    logic                  aw_held;
    logic                  w_held;
    logic [KW-1:0]         aw_word;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;

    // Commit decode
    reg_sel_e              wsel;
    reg_sel_e              rsel;
    logic                  commit;
    logic                  operand_sel;
    logic                  operand_wr;
    logic                  start_req;
    logic                  start_fire;
    logic                  err_set;
    logic                  done_clr;
    logic                  err_clr;
    logic                  wr_slverr;
    logic [KW-1:0]         ar_word;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_slverr;

    // Byte-lane bits of the addresses carry no information.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ready_en keeps every ready low while reset is asserted and for the
    // first edge after release.
    assign s_axi_awready = ready_en && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = ready_en && !w_held && !s_axi_bvalid;
    assign s_axi_arready = ready_en && !s_axi_rvalid;

    assign commit  = aw_held && w_held;
    assign ar_word = s_axi_araddr[ADDR_WIDTH-1:2];

    assign core_data = data_q;
    assign core_wei  = wei_q;
    assign core_bias = bias_q;

    always_comb begin
        wsel        = decode(aw_word);
        operand_sel = (wsel == R_DATA) || (wsel == R_WEI) || (wsel == R_BIAS);
        operand_wr  = commit && operand_sel && !core_busy;
        start_req   = commit && (wsel == R_CTRL) && w_data[0] && w_strb[0];
        // A start while the core is busy, or back-to-back with the previous
        // pulse, is dropped and flagged rather than queued.
        start_fire  = start_req && !core_busy && !core_start;
        err_set     = (commit && operand_sel && core_busy) || (start_req && !start_fire);
        done_clr    = commit && (wsel == R_STATUS) && w_data[0];
        err_clr     = commit && (wsel == R_STATUS) && w_data[2];
        wr_slverr   = (wsel == R_NONE) || (wsel == R_RESULT) || (wsel == R_CYCLES) ||
                      (operand_sel && core_busy);
    end

`ifdef ACCEL_REGBANK_PERF_EN
    logic [31:0] cycles_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            cycles_q <= '0;
        end else if (core_start) begin
            cycles_q <= '0;
        end else if (core_busy) begin
            cycles_q <= sat_inc(cycles_q);
        end
    end
`endif

    always_comb begin
        rsel      = decode(ar_word);
        rd_val    = '0;
        rd_slverr = 1'b0;
        case (rsel)
            R_DATA: begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (ar_word == KW'(i)) rd_val = data_q[i];
                end
            end
            R_WEI: begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (ar_word == K_WEI + KW'(i)) rd_val = wei_q[i];
                end
            end
            R_BIAS:   rd_val = bias_q;
            R_STATUS: begin
                rd_val[0] = done_q;
                rd_val[1] = core_busy;
                rd_val[2] = err_q;
            end
            R_RESULT: rd_val = result_q;
            R_IRQEN:  rd_val[1:0] = irq_en;
`ifdef ACCEL_REGBANK_PERF_EN
            R_CYCLES: rd_val = DATA_WIDTH'(cycles_q);
`endif
            R_NONE:   rd_slverr = 1'b1;
            default:  rd_val = '0;
        endcase
    end

    // Write channel: AW and W are captured independently and committed in
    // the first cycle both are held.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ready_en     <= 1'b0;
            aw_held      <= 1'b0;
            aw_word      <= '0;
            w_held       <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_held <= 1'b1;
                    aw_word <= s_axi_awaddr[ADDR_WIDTH-1:2];
                end
                if (s_axi_wvalid && s_axi_wready) begin
                    w_held <= 1'b1;
                    w_data <= s_axi_wdata;
                    w_strb <= s_axi_wstrb;
                end
                if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data is captured at the AR handshake and held until rready.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_val;
            s_axi_rresp  <= rd_slverr ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    // Operand and configuration registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            data_q <= '0;
            wei_q  <= '0;
            bias_q <= '0;
            irq_en <= '0;
        end else begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (operand_wr && (wsel == R_DATA) && (aw_word == KW'(i)))
                    data_q[i] <= apply_strb(data_q[i], w_data, w_strb);
                if (operand_wr && (wsel == R_WEI) && (aw_word == K_WEI + KW'(i)))
                    wei_q[i] <= apply_strb(wei_q[i], w_data, w_strb);
            end
            if (operand_wr && (wsel == R_BIAS))
                bias_q <= apply_strb(bias_q, w_data, w_strb);
            if (commit && (wsel == R_IRQEN) && w_strb[0])
                irq_en <= w_data[1:0];
        end
    end

    // Status, result, start pulse and interrupt. Set has priority over W1C.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            core_start <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (core_done)     done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;
            if (err_set)       err_q <= 1'b1;
            else if (err_clr)  err_q <= 1'b0;
            if (core_done)     result_q <= core_result;
            core_start <= start_fire;
            irq        <= (done_q && irq_en[0]) || (err_q && irq_en[1]);
        end
    end

endmodule

// File: tb/tb_axil_accel_regbank.sv
// -----------------------------------------------------------------------------
// tb_axil_accel_regbank
//
// Self-checking bench: directed scenarios followed by randomized register
// traffic checked against a word-level reference model of the register map.
// The CYCLES counter scenario runs when ACCEL_REGBANK_PERF_EN is defined;
// otherwise its address is checked as unmapped.
// -----------------------------------------------------------------------------
module tb_axil_accel_regbank;

    localparam int N  = 8;
    localparam int AW = 9;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic            core_start;
    logic [32*N-1:0] core_data;
    logic [32*N-1:0] core_wei;
    logic [31:0]     core_bias;
    logic            core_busy;
    logic            core_done;
    logic [31:0]     core_result;
    logic            irq;

    axil_accel_regbank #(
        .N_WORDS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(32)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .core_start(core_start), .core_data(core_data), .core_wei(core_wei),
        .core_bias(core_bias), .core_busy(core_busy), .core_done(core_done),
        .core_result(core_result), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Start-pulse monitor: number of pulses and longest high run
    int start_cnt = 0;
    int start_run = 0;
    int start_max = 0;
    always @(posedge clk) begin
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_run <= start_run + 1;
            if (start_run + 1 > start_max) start_max <= start_run + 1;
        end else begin
            start_run <= 0;
        end
    end

    // Reference model of the register map
    logic [31:0] m_data [N];
    logic [31:0] m_wei  [N];
    logic [31:0] m_bias;
    logic [31:0] m_result;
    logic [1:0]  m_en;
    logic        m_done;
    logic        m_err;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0;
            m_wei[i]  = '0;
        end
        m_bias = '0; m_result = '0; m_en = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic model_irq();
        return (m_done & m_en[0]) | (m_err & m_en[1]);
    endfunction

    task automatic model_write(input int k, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r, output logic start_exp);
        r = OKAY;
        start_exp = 1'b0;
        if (k <= 2*N) begin
            if (core_busy) begin
                r = SLVERR;
                m_err = 1'b1;
            end else if (k < N) m_data[k] = merge(m_data[k], d, s);
            else if (k < 2*N)   m_wei[k-N] = merge(m_wei[k-N], d, s);
            else                m_bias = merge(m_bias, d, s);
        end else if (k == 2*N+1) begin
            if (d[0] && s[0]) begin
                if (core_busy) m_err = 1'b1;
                else           start_exp = 1'b1;
            end
        end else if (k == 2*N+2) begin
            if (d[0]) m_done = 1'b0;
            if (d[2]) m_err = 1'b0;
        end else if (k == 2*N+4) begin
            if (s[0]) m_en = d[1:0];
        end else begin
            r = SLVERR;
        end
    endtask

    function automatic void model_read(input int k, output logic [31:0] v, output logic [1:0] r);
        v = '0;
        r = OKAY;
        if (k < N)             v = m_data[k];
        else if (k < 2*N)      v = m_wei[k-N];
        else if (k == 2*N)     v = m_bias;
        else if (k == 2*N+1)   v = '0;
        else if (k == 2*N+2)   v = {29'd0, m_err, core_busy, m_done};
        else if (k == 2*N+3)   v = m_result;
        else if (k == 2*N+4)   v = {30'd0, m_en};
        else                   r = SLVERR;
    endfunction

    // Bus tasks: called at posedge+1; return at posedge+1.
    // mode 0: AW and W together, 1: AW first, 2: W first.
    task automatic axi_write(input int k, input logic [31:0] d, input logic [3:0] s, input int mode,
                             input logic done_pulse, input logic [31:0] done_res,
                             output logic [1:0] resp);
        logic aw_done, w_done, fire_aw, fire_w;
        int   n;
        aw_done = 1'b0; w_done = 1'b0; resp = 2'b11; n = 0;
        awaddr = AW'(k*4 + int'($urandom_range(0, 3)));
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done) && n < 40) begin
            if (!aw_done && (mode != 2 || w_done)) awvalid = 1'b1;
            if (!w_done && (mode != 1 || aw_done)) wvalid = 1'b1;
            fire_aw = awvalid && awready;
            fire_w  = wvalid && wready;
            @(posedge clk); #1;
            if (fire_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (fire_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'd0, 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (done_pulse) begin
            core_done = 1'b1;
            core_result = done_res;
        end
        check("b_not_early", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        core_done = 1'b0;
        check("b_latency", 32'(bvalid), 32'd1);
        n = 0;
        while (!bvalid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input int k, input int hold, output logic [31:0] v, output logic [1:0] r);
        logic fire;
        int   n;
        fire = 1'b0; n = 0; v = '0; r = 2'b11;
        araddr  = AW'(k*4 + int'($urandom_range(0, 3)));
        arvalid = 1'b1;
        while (!fire && n < 20) begin
            fire = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!fire) begin
            check("rd_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        check("r_latency", 32'(rvalid), 32'd1);
        v = rdata;
        r = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("r_hold_valid", 32'(rvalid), 32'd1);
            check("r_hold_data", rdata, v);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic read_check(input string tag, input int k, input int hold);
        logic [31:0] v, ev;
        logic [1:0]  r, er;
        model_read(k, ev, er);
        axi_read(k, hold, v, r);
        check({tag, "_data"}, v, ev);
        check({tag, "_resp"}, 32'(r), 32'(er));
    endtask

    task automatic write_check(input string tag, input int k, input logic [31:0] d,
                               input logic [3:0] s, input int mode);
        logic [1:0] r, er;
        logic       se;
        int         sc;
        sc = start_cnt;
        model_write(k, d, s, er, se);
        axi_write(k, d, s, mode, 1'b0, 32'd0, r);
        check({tag, "_bresp"}, 32'(r), 32'(er));
        check({tag, "_starts"}, 32'(start_cnt), 32'(sc + (se ? 1 : 0)));
    endtask

    task automatic pulse_done(input logic [31:0] res);
        core_done   = 1'b1;
        core_result = res;
        @(posedge clk); #1;
        core_done = 1'b0;
        m_done    = 1'b1;
        m_result  = res;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] v;
        int          k, sc;

        rst_n = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        core_busy = 1'b0; core_done = 1'b0; core_result = '0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_resps",   32'({bresp, rresp}), 32'd0);
        check("rst_start",   32'(core_start), 32'd0);
        check("rst_irq",     32'(irq), 32'd0);
        check("rst_bias",    core_bias, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_awready", 32'(awready), 32'd1);

        // Partial-strobe write, W before AW
        write_check("t1", 3, 32'h1234_5678, 4'b0011, 2);
        check("t1_core_data", core_data[3*32 +: 32], 32'h0000_5678);
        read_check("t1_rd", 3, 0);

        // START, completion, W1C
        write_check("t2_start", 2*N+1, 32'h1, 4'hF, 0);
        check("t2_start_width", 32'(start_max), 32'd1);
        pulse_done(32'hDEAD_BEEF);
        read_check("t2_status", 2*N+2, 0);
        read_check("t2_result", 2*N+3, 0);
        write_check("t2_w1c", 2*N+2, 32'h1, 4'hF, 1);
        read_check("t2_status_clr", 2*N+2, 0);

        // Writes while busy
        core_busy = 1'b1;
        write_check("t3_busy_data", 0, 32'hA5A5_5A5A, 4'hF, 0);
        read_check("t3_data0", 0, 0);
        read_check("t3_status", 2*N+2, 0);
        write_check("t3_busy_start", 2*N+1, 32'h1, 4'hF, 0);
        core_busy = 1'b0;

        // Unmapped read with back-pressure
        read_check("t4_unmapped", 31, 5);

        // Interrupt and set-beats-clear
        write_check("t5_clr", 2*N+2, 32'h5, 4'hF, 0);
        write_check("t5_en", 2*N+4, 32'h1, 4'hF, 0);
        check("t5_irq_off", 32'(irq), 32'd0);
        pulse_done(32'h0000_1111);
        check("t5_irq_on", 32'(irq), 32'd1);
        model_write(2*N+2, 32'h1, 4'hF, r, v[0]);
        axi_write(2*N+2, 32'h1, 4'hF, 0, 1'b1, 32'h0000_2222, r);
        m_done = 1'b1;
        m_result = 32'h0000_2222;
        check("t5_race_bresp", 32'(r), 32'(OKAY));
        check("t5_race_irq", 32'(irq), 32'd1);
        read_check("t5_race_status", 2*N+2, 0);
        read_check("t5_race_result", 2*N+3, 0);

`ifdef ACCEL_REGBANK_PERF_EN
        write_check("t6_start", 2*N+1, 32'h1, 4'hF, 0);
        core_busy = 1'b1;
        repeat (17) @(posedge clk);
        #1 core_busy = 1'b0;
        axi_read(2*N+5, 0, v, r);
        check("t6_cycles", v, 32'd17);
        check("t6_cycles_resp", 32'(r), 32'(OKAY));
`else
        read_check("t6_cycles_unmapped", 2*N+5, 0);
`endif
        write_check("t6_cycles_wr", 2*N+5, 32'h5, 4'hF, 0);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            int op;
            core_busy = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 7) k = $urandom_range(0, 2*N+5);
            else                          k = $urandom_range(0, 127);
            if (op < 4) begin
                write_check("rnd_wr", k, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            end else if (op < 8) begin
`ifdef ACCEL_REGBANK_PERF_EN
                if (k == 2*N+5) k = 2*N+2;
`endif
                read_check("rnd_rd", k, $urandom_range(0, 2));
            end else if (op == 8) begin
                pulse_done($urandom);
            end else begin
                write_check("rnd_w1c", 2*N+2, $urandom, 4'hF, $urandom_range(0, 2));
            end
            check("rnd_irq", 32'(irq), 32'(model_irq()));
        end
        core_busy = 1'b0;

        // Reset in the middle of a transaction
        write_check("t7_en", 2*N+4, 32'h1, 4'hF, 0);
        pulse_done(32'h0BAD_F00D);
        check("t7_irq_before", 32'(irq), 32'd1);
`ifdef ACCEL_REGBANK_PERF_EN
        write_check("t7_start", 2*N+1, 32'h1, 4'hF, 0);
        core_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
`endif
        awaddr = '0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        check("t7_bvalid_pending", 32'(bvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_bvalid", 32'(bvalid), 32'd0);
        check("t7_rst_irq", 32'(irq), 32'd0);
        check("t7_rst_data0", core_data[31:0], 32'd0);
        core_busy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        read_check("t7_status", 2*N+2, 0);
        read_check("t7_irqen", 2*N+4, 0);
        read_check("t7_data0", 0, 0);
`ifdef ACCEL_REGBANK_PERF_EN
        axi_read(2*N+5, 0, v, r);
        check("t7_cycles", v, 32'd0);
`endif
        sc = start_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("t7_no_late_start", 32'(start_cnt), 32'(sc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
